// File: rtl/lcd_pkg.sv
// Shared constants, types and decode helpers for the HD44780 bus monitor.
package lcd_pkg;

    localparam int unsigned AC_W      = 7;
    localparam int unsigned NUM_BYTES = 32;
    localparam int unsigned FRAME_W   = NUM_BYTES * 8;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Instruction class masks; a command is classified by its highest set bit.
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [AC_W-1:0] ROW1_BASE    = 7'h00;
    localparam logic [AC_W-1:0] ROW2_BASE    = 7'h40;
    localparam logic [AC_W-1:0] ROW_MASK     = 7'h70;
    localparam logic [AC_W-1:0] LINE1_END_2L = 7'h27;
    localparam logic [AC_W-1:0] LINE2_END_2L = 7'h67;
    localparam logic [AC_W-1:0] LINE_END_1L  = 7'h4F;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } frame_addr_t;

    function automatic cmd_e decode_cmd(input logic [7:0] op);
        cmd_e cmd;
        if      ((op & OP_DDRAM) != 8'h00) cmd = CMD_DDRAM;
        else if ((op & OP_CGRAM) != 8'h00) cmd = CMD_CGRAM;
        else if ((op & OP_FUNC)  != 8'h00) cmd = CMD_FUNC;
        else if ((op & OP_SHIFT) != 8'h00) cmd = CMD_SHIFT;
        else if ((op & OP_DISP)  != 8'h00) cmd = CMD_DISP;
        else if ((op & OP_ENTRY) != 8'h00) cmd = CMD_ENTRY;
        else if ((op & OP_HOME)  != 8'h00) cmd = CMD_HOME;
        else if ((op & OP_CLEAR) != 8'h00) cmd = CMD_CLEAR;
        else                               cmd = CMD_NOP;
        return cmd;
    endfunction

    // Only the first 16 columns of each row are visible in the frame image.
    function automatic frame_addr_t map_addr(input logic [AC_W-1:0] a);
        frame_addr_t m;
        m.valid = 1'b0;
        m.idx   = '0;
        if ((a & ROW_MASK) == ROW1_BASE) begin
            m.valid = 1'b1;
            m.idx   = {1'b0, a[3:0]};
        end else if ((a & ROW_MASK) == ROW2_BASE) begin
            m.valid = 1'b1;
            m.idx   = {1'b1, a[3:0]};
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Address counter +/-1 step with HD44780 line wrap.
module lcd_ac_step
    import lcd_pkg::*;
(
    input  logic [AC_W-1:0] ac_i,
    input  logic            inc_i,
    input  logic            two_line_i,
    output logic [AC_W-1:0] ac_o
);

    always_comb begin
        ac_o = inc_i ? (ac_i + AC_W'(1)) : (ac_i - AC_W'(1));
        if (two_line_i) begin
            if (inc_i && (ac_i == LINE1_END_2L))       ac_o = ROW2_BASE;
            else if (inc_i && (ac_i == LINE2_END_2L))  ac_o = ROW1_BASE;
            else if (!inc_i && (ac_i == ROW1_BASE))    ac_o = LINE2_END_2L;
            else if (!inc_i && (ac_i == ROW2_BASE))    ac_o = LINE1_END_2L;
        end else begin
            if (inc_i && (ac_i == LINE_END_1L))        ac_o = ROW1_BASE;
            else if (!inc_i && (ac_i == ROW1_BASE))    ac_o = LINE_END_1L;
        end
    end

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus monitor: decodes driver writes into a 2x16 frame image,
// mode bits, address counter and an emulated busy timer.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_SHORT = 2000,
    parameter int unsigned BUSY_LONG  = 76500
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               lcd_en,
    input  logic               rs,
    input  logic               rw,
    input  logic [7:0]         data,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    output logic [AC_W-1:0]    ac,
    output logic               busy,
    output logic               display_on,
    output logic               cursor_on,
    output logic               blink_on,
    output logic               entry_inc,
    output logic               entry_shift,
    output logic               two_line,
    output logic               dl8,
    output logic               err_busy
);

    localparam int unsigned BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
    localparam int unsigned CNT_W    = (BUSY_MAX < 1) ? 1 : $clog2(BUSY_MAX + 1);

    logic en_s1_q, en_s2_q, en_s3_q;
    logic rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [AC_W-1:0]    ac_q, ac_d;
    logic               cgram_q, cgram_d;
    logic               entry_inc_q, entry_inc_d;
    logic               entry_shift_q, entry_shift_d;
    logic               display_on_q, display_on_d;
    logic               cursor_on_q, cursor_on_d;
    logic               blink_on_q, blink_on_d;
    logic               two_line_q, two_line_d;
    logic               dl8_q, dl8_d;
    logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic               busy_q, busy_d;
    logic               err_busy_q, err_busy_d;
    logic               frame_valid_q, frame_valid_d;

    logic            wr_accept;
    logic            step_inc;
    logic [AC_W-1:0] ac_next;
    cmd_e            cmd;
    frame_addr_t     wr_addr;

    // A write commits on the synchronized falling edge of the strobe; reads are ignored.
    assign wr_accept = en_s3_q & ~en_s2_q & ~rw_s2_q;
    assign cmd       = decode_cmd(data_s2_q);
    assign wr_addr   = map_addr(ac_q);
    assign step_inc  = rs_s2_q ? entry_inc_q : data_s2_q[2];

    lcd_ac_step u_ac_step (
        .ac_i       (ac_q),
        .inc_i      (step_inc),
        .two_line_i (two_line_q),
        .ac_o       (ac_next)
    );

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            en_s1_q       <= 1'b0;
            en_s2_q       <= 1'b0;
            en_s3_q       <= 1'b0;
            rs_s1_q       <= 1'b0;
            rs_s2_q       <= 1'b0;
            rw_s1_q       <= 1'b0;
            rw_s2_q       <= 1'b0;
            data_s1_q     <= '0;
            data_s2_q     <= '0;
            frame_q       <= {NUM_BYTES{SPACE_CHAR}};
            ac_q          <= '0;
            cgram_q       <= 1'b0;
            entry_inc_q   <= 1'b1;
            entry_shift_q <= 1'b0;
            display_on_q  <= 1'b0;
            cursor_on_q   <= 1'b0;
            blink_on_q    <= 1'b0;
            two_line_q    <= 1'b0;
            dl8_q         <= 1'b0;
            busy_cnt_q    <= '0;
            busy_q        <= 1'b0;
            err_busy_q    <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            en_s1_q       <= lcd_en;
            en_s2_q       <= en_s1_q;
            en_s3_q       <= en_s2_q;
            rs_s1_q       <= rs;
            rs_s2_q       <= rs_s1_q;
            rw_s1_q       <= rw;
            rw_s2_q       <= rw_s1_q;
            data_s1_q     <= data;
            data_s2_q     <= data_s1_q;
            frame_q       <= frame_d;
            ac_q          <= ac_d;
            cgram_q       <= cgram_d;
            entry_inc_q   <= entry_inc_d;
            entry_shift_q <= entry_shift_d;
            display_on_q  <= display_on_d;
            cursor_on_q   <= cursor_on_d;
            blink_on_q    <= blink_on_d;
            two_line_q    <= two_line_d;
            dl8_q         <= dl8_d;
            busy_cnt_q    <= busy_cnt_d;
            busy_q        <= busy_d;
            err_busy_q    <= err_busy_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Instruction/data execution; busy stays high for exactly the loaded count.
    always_comb begin
        frame_d       = frame_q;
        ac_d          = ac_q;
        cgram_d       = cgram_q;
        entry_inc_d   = entry_inc_q;
        entry_shift_d = entry_shift_q;
        display_on_d  = display_on_q;
        cursor_on_d   = cursor_on_q;
        blink_on_d    = blink_on_q;
        two_line_d    = two_line_q;
        dl8_d         = dl8_q;
        err_busy_d    = err_busy_q;
        frame_valid_d = 1'b0;
        busy_cnt_d    = (busy_cnt_q != '0) ? (busy_cnt_q - CNT_W'(1)) : '0;

        if (wr_accept) begin
            if (busy_q) err_busy_d = 1'b1;
            if (rs_s2_q) begin
                busy_cnt_d = CNT_W'(BUSY_SHORT);
                if (!cgram_q) begin
                    if (wr_addr.valid) frame_d[{wr_addr.idx, 3'b000} +: 8] = data_s2_q;
                    ac_d = ac_next;
                end
            end else begin
                if (cmd != CMD_NOP) busy_cnt_d = CNT_W'(BUSY_SHORT);
                case (cmd)
                    CMD_CLEAR: begin
                        frame_d     = {NUM_BYTES{SPACE_CHAR}};
                        ac_d        = '0;
                        entry_inc_d = 1'b1;
                        cgram_d     = 1'b0;
                        busy_cnt_d  = CNT_W'(BUSY_LONG);
                    end
                    CMD_HOME: begin
                        ac_d          = '0;
                        cgram_d       = 1'b0;
                        busy_cnt_d    = CNT_W'(BUSY_LONG);
                        frame_valid_d = 1'b1;
                    end
                    CMD_ENTRY: begin
                        entry_inc_d   = data_s2_q[1];
                        entry_shift_d = data_s2_q[0];
                    end
                    CMD_DISP: begin
                        display_on_d = data_s2_q[2];
                        cursor_on_d  = data_s2_q[1];
                        blink_on_d   = data_s2_q[0];
                    end
                    CMD_SHIFT: begin
                        if (!data_s2_q[3]) ac_d = ac_next;
                    end
                    CMD_FUNC: begin
                        dl8_d      = data_s2_q[4];
                        two_line_d = data_s2_q[3];
                    end
                    CMD_CGRAM: cgram_d = 1'b1;
                    CMD_DDRAM: begin
                        ac_d    = data_s2_q[6:0];
                        cgram_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (busy_cnt_d != '0);
    end

    assign frame_out   = frame_q;
    assign frame_valid = frame_valid_q;
    assign ac          = ac_q;
    assign busy        = busy_q;
    assign display_on  = display_on_q;
    assign cursor_on   = cursor_on_q;
    assign blink_on    = blink_on_q;
    assign entry_inc   = entry_inc_q;
    assign entry_shift = entry_shift_q;
    assign two_line    = two_line_q;
    assign dl8         = dl8_q;
    assign err_busy    = err_busy_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: directed scenarios plus random bus traffic
// checked against a behavioural HD44780 model.
module tb_lcd_bus_monitor;

    localparam int unsigned BS = 150;
    localparam int unsigned BL = 76500;

    logic         clk = 1'b0;
    logic         rst, lcd_en, rs, rw;
    logic [7:0]   data;
    logic [255:0] frame_out;
    logic         frame_valid, busy, err_busy;
    logic [6:0]   ac;
    logic         display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, dl8;
    logic [6:0]   dut_modes;

    assign dut_modes = {display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, dl8};

    lcd_bus_monitor #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
        .CLOCK_50(clk), .rst(rst), .lcd_en(lcd_en), .rs(rs), .rw(rw), .data(data),
        .frame_out(frame_out), .frame_valid(frame_valid), .ac(ac), .busy(busy),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .entry_shift(entry_shift), .two_line(two_line),
        .dl8(dl8), .err_busy(err_busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the display controller.
    logic [7:0] m_frame [32];
    int m_ac;
    bit m_cgram, m_inc, m_shift, m_disp, m_cur, m_blink, m_two, m_dl8, m_err;
    int m_load_at, m_busy_len;

    typedef struct {
        logic [255:0] frame;
        logic [6:0]   modes;
        logic         err;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [255:0] m_frame_vec();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = m_frame[k];
        return v;
    endfunction

    function automatic logic [6:0] m_modes();
        return {m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_dl8};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) m_frame[k] = 8'h20;
        m_ac = 0; m_cgram = 0; m_inc = 1; m_shift = 0; m_disp = 0; m_cur = 0;
        m_blink = 0; m_two = 0; m_dl8 = 0; m_err = 0; m_load_at = 0; m_busy_len = 0;
    endfunction

    // Positions along the display as one circular line of 80 cells.
    function automatic int step_ac(int a, bit inc, bit two);
        int idx;
        if (two) begin
            if (a <= 'h27) idx = a;
            else if (a >= 'h40 && a <= 'h67) idx = a - 'h40 + 40;
            else return (inc ? a + 1 : a - 1) & 'h7F;
            idx = (idx + (inc ? 1 : 79)) % 80;
            return (idx < 40) ? idx : idx - 40 + 'h40;
        end
        if (a <= 'h4F) return (a + (inc ? 1 : 79)) % 80;
        return (inc ? a + 1 : a - 1) & 'h7F;
    endfunction

    function automatic void model_xact(bit r_s, bit r_w, logic [7:0] d, int t);
        int load;
        exp_t e;
        if (r_w) return;
        if (m_busy_len > 0 && (t - m_load_at) >= 1 && (t - m_load_at) <= m_busy_len) m_err = 1;
        load = BS;
        if (r_s) begin
            if (!m_cgram) begin
                if (m_ac <= 'h0F) m_frame[m_ac] = d;
                else if (m_ac >= 'h40 && m_ac <= 'h4F) m_frame[m_ac - 'h40 + 16] = d;
                m_ac = step_ac(m_ac, m_inc, m_two);
            end
        end else if (d == 8'h00) load = 0;
        else if (d >= 8'h80) begin m_ac = int'(d) - 'h80; m_cgram = 0; end
        else if (d >= 8'h40) m_cgram = 1;
        else if (d >= 8'h20) begin m_dl8 = d[4]; m_two = d[3]; end
        else if (d >= 8'h10) begin if (!d[3]) m_ac = step_ac(m_ac, d[2], m_two); end
        else if (d >= 8'h08) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        else if (d >= 8'h04) begin m_inc = d[1]; m_shift = d[0]; end
        else if (d >= 8'h02) begin
            m_ac = 0; m_cgram = 0; load = BL;
            e.frame = m_frame_vec(); e.modes = m_modes(); e.err = m_err;
            sb_q.push_back(e);
        end else begin
            for (int k = 0; k < 32; k++) m_frame[k] = 8'h20;
            m_ac = 0; m_inc = 1; m_cgram = 0; load = BL;
        end
        if (load != 0) begin m_load_at = t; m_busy_len = load; end
    endfunction

    task automatic xact(input bit r_s, input bit r_w, input logic [7:0] d);
        @(negedge clk);
        rs = r_s; rw = r_w; data = d; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        model_xact(r_s, r_w, d, cyc);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin @(negedge clk); n++; end
        if (busy) begin
            n_checks++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", limit);
        end
    endtask

    task automatic chk_state(input string name);
        chk({name, "_ac"}, 256'(ac), 256'(m_ac));
        chk({name, "_frame"}, frame_out, m_frame_vec());
        chk({name, "_modes"}, 256'(dut_modes), 256'(m_modes()));
        chk({name, "_err"}, 256'(err_busy), 256'(m_err));
    endtask

    // Monitor: every frame_valid pulse is checked against the queued home snapshot.
    bit fv_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && frame_valid) begin
            chk("frame_valid_width", 256'(fv_prev), 256'(0));
            if (!fv_prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame_valid: got pulse, expected none");
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_frame", frame_out, e.frame);
                    chk("sb_ac", 256'(ac), 256'(0));
                    chk("sb_modes", 256'(dut_modes), 256'(e.modes));
                    chk("sb_err", 256'(err_busy), 256'(e.err));
                    chk("sb_busy", 256'(busy), 256'(1));
                end
            end
        end
        fv_prev = frame_valid;
    end

    int busy_run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy) busy_run++;
        else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
        end
    end

    initial begin
        #(20 * 98000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        logic [255:0] pre_frame;
        int pre_ac, r;
        rst = 1'b1; lcd_en = 1'b0; rs = 1'b0; rw = 1'b0; data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_frame", frame_out, {32{8'h20}});
        chk("reset_ac", 256'(ac), 256'(0));
        chk("reset_modes", 256'(dut_modes), 256'(7'b0001000));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_err", 256'(err_busy), 256'(0));

        // Initialisation and a full row of text.
        xact(0, 0, 8'h38); wait_idle(1000);
        @(negedge clk);
        chk("busy_short_len", 256'(last_run), 256'(BS));
        xact(0, 0, 8'h0C); wait_idle(1000);
        xact(0, 0, 8'h06); wait_idle(1000);
        s = "2024-05-01 12:30";
        for (int i = 0; i < 16; i++) begin xact(1, 0, 8'(s[i])); wait_idle(1000); end
        chk_state("row1");
        chk("row1_ac_lit", 256'(ac), 256'(7'h10));
        chk("row1_mode_lit", 256'({dl8, two_line, display_on}), 256'(3'b111));

        // Row 2 write, then home with the long busy time.
        xact(0, 0, 8'hC0); wait_idle(1000);
        xact(1, 0, 8'h53); wait_idle(1000);
        chk("row2_byte16", 256'(frame_out[135:128]), 256'(8'h53));
        xact(0, 0, 8'h02); wait_idle(80000);
        @(negedge clk);
        chk("busy_long_len", 256'(last_run), 256'(BL));
        chk("home_pulse_seen", 256'(sb_q.size()), 256'(0));
        chk("home_ac", 256'(ac), 256'(0));

        // Two-line wrap points and shift.
        xact(0, 0, 8'hA7); wait_idle(1000);
        chk("ac_0x27", 256'(ac), 256'(7'h27));
        xact(1, 0, 8'h5A); wait_idle(1000);
        chk("wrap_27_40", 256'(ac), 256'(7'h40));
        chk_state("unmapped");
        xact(0, 0, 8'h04); wait_idle(1000);
        xact(0, 0, 8'h80); wait_idle(1000);
        xact(1, 0, 8'h41); wait_idle(1000);
        chk("wrap_00_67", 256'(ac), 256'(7'h67));
        chk("dec_byte0", 256'(frame_out[7:0]), 256'(8'h41));
        xact(0, 0, 8'h14); wait_idle(1000);
        chk("shift_67_00", 256'(ac), 256'(7'h00));
        xact(0, 0, 8'h1C); wait_idle(1000);
        chk_state("disp_shift");

        // Reads never change anything.
        for (int i = 0; i < 6; i++) begin
            xact(1'($urandom_range(0, 1)), 1, 8'($urandom));
            chk("read_ac", 256'(ac), 256'(m_ac));
            chk("read_frame", frame_out, m_frame_vec());
            chk("read_busy", 256'(busy), 256'(0));
        end

        // Write while busy.
        xact(0, 0, 8'h06); wait_idle(1000);
        xact(0, 0, 8'h80); wait_idle(1000);
        chk("err_before", 256'(err_busy), 256'(0));
        xact(1, 0, 8'h78);
        repeat (91) @(negedge clk);
        xact(1, 0, 8'h79); wait_idle(1000);
        chk("busy_write_bytes", 256'(frame_out[15:0]), 256'(16'h7978));
        chk_state("busy_write");
        xact(0, 0, 8'h0F); wait_idle(1000);
        chk("err_sticky", 256'(err_busy), 256'(1));

        // Fill, clear, then reset in the middle of the long busy time.
        xact(0, 0, 8'h80);
        for (int i = 0; i < 16; i++) xact(1, 0, 8'($urandom_range(33, 126)));
        xact(0, 0, 8'hC0);
        for (int i = 0; i < 16; i++) xact(1, 0, 8'($urandom_range(33, 126)));
        xact(0, 0, 8'h03);
        xact(0, 0, 8'h01);
        chk("clear_frame", frame_out, {32{8'h20}});
        chk_state("clear");
        xact(1, 0, 8'h57);
        @(negedge clk);
        rst = 1'b1; lcd_en = 1'b1; rs = 1'b1; rw = 1'b0; data = 8'h51;
        @(negedge clk);
        model_reset();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_frame", frame_out, {32{8'h20}});
        chk("rst_err", 256'(err_busy), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("en_high_no_accept", 256'({busy, ac}), 256'(0));
        lcd_en = 1'b0;
        model_xact(1, 0, 8'h51, cyc);
        repeat (5) @(negedge clk);
        chk("first_fall_ac", 256'(ac), 256'(1));
        chk("first_fall_byte", 256'(frame_out[7:0]), 256'(8'h51));

        // Random traffic; every home is scored by the monitor.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      xact(1, 0, 8'($urandom));
            else if (r < 60) xact(1'($urandom_range(0, 1)), 1, 8'($urandom));
            else if (r < 70) xact(0, 0, 8'h80 | 8'($urandom_range(0, 127)));
            else if (r < 73) xact(0, 0, 8'h40 | 8'($urandom_range(0, 63)));
            else if (r < 77) xact(0, 0, 8'h04 | 8'($urandom_range(0, 3)));
            else if (r < 81) xact(0, 0, 8'h20 | 8'($urandom_range(0, 31)));
            else if (r < 86) xact(0, 0, 8'h10 | 8'($urandom_range(0, 15)));
            else if (r < 89) xact(0, 0, 8'h08 | 8'($urandom_range(0, 7)));
            else if (r < 90) xact(0, 0, 8'h01);
            else if (r < 92) xact(0, 0, 8'h00);
            else             xact(0, 0, 8'h02 | 8'($urandom_range(0, 1)));
        end
        chk_state("random_end");
        xact(0, 0, 8'h02);
        repeat (3) @(negedge clk);
        chk("sb_drained", 256'(sb_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_monitor.md
LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 SHALL use parameter BUSY_SHORT, default 2000, meaning busy cycles after a normal instruction or data write (40 us at 50 MHz).
REQ-002 SHALL use parameter BUSY_LONG, default 76500, meaning busy cycles after clear or home (1.53 ms).
REQ-003 SHALL have a single clock, CLOCK_50 (input, 1): all logic is on its rising edge.
REQ-004 SHALL have rst (input, 1): reset is synchronous and active-high.
REQ-005 SHALL have lcd_en, rs, rw (input, 1 each): the HD44780 bus strobe, register select and read/write, taken from the driver outputs.
REQ-006 SHALL have data (input, 8): the HD44780 bus data byte.
REQ-007 SHALL have frame_out (output, 256): the 32-character image, byte k in bits [8k+7:8k]; bytes 0-15 are row 1 and bytes 16-31 are row 2.
REQ-008 SHALL have frame_valid (output, 1): a one-cycle pulse when a home instruction is accepted.
REQ-009 SHALL have ac (output, 7): the address counter.
REQ-010 SHALL have busy (output, 1): high while the emulated instruction time is running.
REQ-011 SHALL have display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, dl8 (output, 1 each): the decoded mode bits.
REQ-012 SHALL have err_busy (output, 1): a sticky flag that sets when any write is accepted while busy is high.

Function
REQ-013 SHALL pass lcd_en through a 2-FF synchronizer; rs, rw and data SHALL go through matching 2-stage delays so all signals stay aligned.
REQ-014 SHALL accept a transaction on the cycle a synchronized lcd_en falling edge is detected; all state effects SHALL be visible on the next cycle.
REQ-015 SHALL ignore transactions with rw=1 entirely: no state change and no busy.
REQ-016 SHALL decode a command (rs=0) by its highest set bit:
- 0x01 clear: fill all 32 bytes with 0x20, ac=0, entry_inc=1, select DDRAM, load BUSY_LONG.
- 0x02/0x03 home: ac=0, select DDRAM, load BUSY_LONG, pulse frame_valid.
- 0x04-0x07 entry mode: entry_inc=data[1], entry_shift=data[0].
- 0x08-0x0F display control: display_on=data[2], cursor_on=data[1], blink_on=data[0].
- 0x10-0x1F shift: if data[3]=0, step ac by 1 (right if data[2]=1, left otherwise) with wrap; if data[3]=1, no frame or ac change.
- 0x20-0x3F function set: dl8=data[4], two_line=data[3].
- 0x40-0x7F CGRAM address: select CGRAM mode; ac unchanged.
- 0x80-0xFF DDRAM address: ac=data[6:0], select DDRAM.
- 0x00: no operation, no busy load.
REQ-017 SHALL load the busy counter with BUSY_SHORT on every other accepted write, including data writes.
REQ-018 SHALL, for a data write (rs=0... rs=1, rw=0) in DDRAM mode, store data at the byte mapped from ac, then step ac per entry_inc; entry_shift SHALL have no effect on the frame.
REQ-019 SHALL, for a data write in CGRAM mode, discard the byte and leave ac unchanged.
REQ-020 SHALL map addresses as follows: 0x00-0x0F to bytes 0-15 and 0x40-0x4F to bytes 16-31; any other address SHALL discard the write while ac still steps.
REQ-021 SHALL wrap ac in two_line mode as: increment 0x27->0x40 and 0x67->0x00; decrement 0x00->0x67 and 0x40->0x27.
REQ-022 SHALL wrap ac in one-line mode as: increment 0x4F->0x00; decrement 0x00->0x4F.
REQ-023 SHALL still execute a write accepted while busy is high, set err_busy, and reload the busy counter.
REQ-024 SHALL keep busy high exactly N cycles after loading N, then drop it; the counter SHALL saturate at 0.
REQ-025 SHALL register frame_out directly from the buffer; on a frame_valid pulse, frame_out SHALL already include every write accepted before the home.

Reset
REQ-026 SHALL, under rst, set: frame_out to all 0x20; ac=0; DDRAM mode; entry_inc=1; entry_shift, display_on, cursor_on, blink_on, two_line, dl8, busy, err_busy and frame_valid all 0; synchronizer and delay stages to 0.
REQ-027 SHALL abort any in-progress busy count under rst; lcd_en held high through reset SHALL NOT produce an accept until its first post-reset falling edge.

Structure
REQ-028 SHALL place the instruction opcode masks, the 0x20 space code, the row base addresses and the wrap limits in package lcd_pkg.
REQ-029 SHALL implement the ac step and wrap logic in sub-module lcd_ac_step (inputs ac, inc, two_line; output next ac).

Verification
REQ-030 SHALL verify: function set 0x38, then 0x0C, 0x06, then 16 data bytes "2024-05-01 12:30" from ac=0 -> bytes 0-15 match, ac=0x10, dl8=1, two_line=1, display_on=1.
REQ-031 SHALL verify: 0x80|0x40 then data 'S' -> byte 16=0x53; a subsequent 0x02 -> frame_valid for 1 cycle, ac=0, busy high for 76500 cycles.
REQ-032 SHALL verify: two_line=1, ac=0x27, data write -> ac=0x40, nothing stored; entry_inc=0 at ac=0x00 -> ac=0x67.
REQ-033 SHALL verify: a second data write 100 cycles after the first -> both bytes stored, err_busy=1 and remaining 1 until rst.
REQ-034 SHALL verify: 0x01 after frame fill -> all bytes 0x20, ac=0; rst asserted mid-busy -> busy=0 next cycle, frame all 0x20.
REQ-035 SHALL verify: rw=1 strobes interleaved -> no change in ac, frame or busy.
